// File: rtl/demux32_collector_if.sv
// Bit-collector bus: the producer supplies an indexed bit and an optional clear.
// The collector returns the stored word, the fill mask, the fill count and status flags.
interface demux32_collector_if #(
  parameter int unsigned N = 32
);
  localparam int unsigned S = $clog2(N);

  logic         ena;
  logic         clear;
  logic [S-1:0] select;
  logic         in;
  logic [N-1:0] out;
  logic [N-1:0] written;
  logic [S:0]   count;
  logic         done;
  logic         dup;

  modport master (
    output ena, clear, select, in,
    input  out, written, count, done, dup
  );

  modport slave (
    input  ena, clear, select, in,
    output out, written, count, done, dup
  );
endinterface

// File: rtl/demux32_collector.sv
// Sequential 1:N demultiplexer: writes one addressed bit per enabled cycle into a
// stored word, tracking which positions have been filled since the last clear.
module demux32_collector #(
  parameter int unsigned N = 32
) (
  input logic               clk,
  input logic               rst,
  demux32_collector_if.slave bus
);
  localparam int unsigned S = $clog2(N);
  localparam logic [S:0]  FULL = (S+1)'(N);

  logic [N-1:0] out_q, out_d;
  logic [N-1:0] written_q, written_d;
  logic [S:0]   count_q, count_d;
  logic         dup_q, dup_d;

  logic [N-1:0] base_out, base_written;
  logic [S:0]   base_count;

  // Clear is applied to the base state first, so a same-cycle write lands on an empty word.
  always_comb begin
    base_out     = bus.clear ? '0 : out_q;
    base_written = bus.clear ? '0 : written_q;
    base_count   = bus.clear ? '0 : count_q;

    out_d     = base_out;
    written_d = base_written;
    count_d   = base_count;
    dup_d     = 1'b0;

    if (bus.ena) begin
      out_d[bus.select] = bus.in;
      if (base_written[bus.select]) begin
        dup_d = 1'b1;
      end else begin
        written_d[bus.select] = 1'b1;
        count_d               = base_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      written_q <= '0;
      count_q   <= '0;
      dup_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      written_q <= written_d;
      count_q   <= count_d;
      dup_q     <= dup_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.written = written_q;
  assign bus.count   = count_q;
  assign bus.dup     = dup_q;
  assign bus.done    = (count_q == FULL);
endmodule

// File: tb/tb_demux32_collector.sv
// Directed self-checking bench for demux32_collector with hand-computed expectations.
module tb_demux32_collector;
  logic clk = 1'b0;
  logic rst;
  int unsigned total = 0;
  int unsigned bad   = 0;

  demux32_collector_if #(.N(32)) bus ();

  demux32_collector #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.ena = 1'b1; bus.clear = 1'b0; bus.select = 5'd7; bus.in = 1'b1;
    tick();
    tick();
    total++; if (bus.out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", bus.out, 32'h0); end
    total++; if (bus.written !== 32'h0) begin bad++; $display("FAIL reset_written got=%h exp=%h", bus.written, 32'h0); end
    total++; if (bus.count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.dup !== 1'b0) begin bad++; $display("FAIL reset_dup got=%b exp=0", bus.dup); end
    rst = 1'b0; bus.ena = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] pat;
    pat = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) begin
      bus.ena = 1'b1; bus.select = 5'(i); bus.in = pat[i];
      tick();
      total++; if (bus.dup !== 1'b0) begin bad++; $display("FAIL fill_dup i=%0d got=%b exp=0", i, bus.dup); end
      total++; if (bus.count !== 6'(i + 1)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, bus.count, i + 1); end
      if (i == 30) begin
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL fill_done_early got=%b exp=0", bus.done); end
      end
    end
    bus.ena = 1'b0;
    total++; if (bus.out !== 32'hDEADBEEF) begin bad++; $display("FAIL fill_out got=%h exp=%h", bus.out, 32'hDEADBEEF); end
    total++; if (bus.written !== 32'hFFFFFFFF) begin bad++; $display("FAIL fill_written got=%h exp=%h", bus.written, 32'hFFFFFFFF); end
    total++; if (bus.count !== 6'd32) begin bad++; $display("FAIL fill_count_final got=%0d exp=32", bus.count); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL fill_done got=%b exp=1", bus.done); end
  endtask

  task automatic test_overwrite_full();
    bus.ena = 1'b1; bus.select = 5'd5; bus.in = 1'b0;
    tick();
    bus.ena = 1'b0;
    total++; if (bus.out !== 32'hDEADBECF) begin bad++; $display("FAIL ovw_out got=%h exp=%h", bus.out, 32'hDEADBECF); end
    total++; if (bus.count !== 6'd32) begin bad++; $display("FAIL ovw_count got=%0d exp=32", bus.count); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL ovw_done got=%b exp=1", bus.done); end
    total++; if (bus.dup !== 1'b1) begin bad++; $display("FAIL ovw_dup got=%b exp=1", bus.dup); end
    tick();
    total++; if (bus.dup !== 1'b0) begin bad++; $display("FAIL ovw_dup_fall got=%b exp=0", bus.dup); end
    total++; if (bus.count !== 6'd32) begin bad++; $display("FAIL ovw_count_hold got=%0d exp=32", bus.count); end
  endtask

  task automatic test_clear();
    bus.clear = 1'b1; bus.ena = 1'b0;
    tick();
    total++; if (bus.out !== 32'h0) begin bad++; $display("FAIL clr_out got=%h exp=%h", bus.out, 32'h0); end
    total++; if (bus.written !== 32'h0) begin bad++; $display("FAIL clr_written got=%h exp=%h", bus.written, 32'h0); end
    total++; if (bus.count !== 6'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", bus.count); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL clr_done got=%b exp=0", bus.done); end
    bus.ena = 1'b1; bus.select = 5'd31; bus.in = 1'b1;
    tick();
    bus.clear = 1'b0; bus.ena = 1'b0;
    total++; if (bus.out !== 32'h80000000) begin bad++; $display("FAIL clrw_out got=%h exp=%h", bus.out, 32'h80000000); end
    total++; if (bus.written !== 32'h80000000) begin bad++; $display("FAIL clrw_written got=%h exp=%h", bus.written, 32'h80000000); end
    total++; if (bus.count !== 6'd1) begin bad++; $display("FAIL clrw_count got=%0d exp=1", bus.count); end
    total++; if (bus.dup !== 1'b0) begin bad++; $display("FAIL clrw_dup got=%b exp=0", bus.dup); end
  endtask

  task automatic test_idle_random();
    logic [31:0] mo, mw;
    int unsigned mc;
    logic        md;
    int unsigned s;
    logic        b;
    mo = 32'h80000000; mw = 32'h80000000; mc = 1;
    for (int i = 0; i < 10; i++) begin
      bus.ena = 1'b0; bus.select = 5'($urandom); bus.in = i[0];
      tick();
      total++; if (bus.out !== mo || bus.written !== mw || bus.count !== 6'(mc) || bus.dup !== 1'b0)
        begin bad++; $display("FAIL idle_hold i=%0d got out=%h w=%h c=%0d dup=%b exp out=%h w=%h c=%0d dup=0",
                              i, bus.out, bus.written, bus.count, bus.dup, mo, mw, mc); end
    end
    for (int i = 0; i < 64; i++) begin
      s = $urandom_range(0, 31);
      b = 1'($urandom);
      bus.ena = 1'b1; bus.select = 5'(s); bus.in = b;
      md = mw[s];
      mo[s] = b;
      if (!md) begin mw[s] = 1'b1; mc++; end
      tick();
      total++; if (bus.out !== mo) begin bad++; $display("FAIL rnd_out i=%0d got=%h exp=%h", i, bus.out, mo); end
      total++; if (bus.written !== mw) begin bad++; $display("FAIL rnd_written i=%0d got=%h exp=%h", i, bus.written, mw); end
      total++; if (bus.count !== 6'(mc)) begin bad++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, bus.count, mc); end
      total++; if (bus.dup !== md) begin bad++; $display("FAIL rnd_dup i=%0d got=%b exp=%b", i, bus.dup, md); end
      total++; if (bus.done !== (mc == 32)) begin bad++; $display("FAIL rnd_done i=%0d got=%b exp=%b", i, bus.done, (mc == 32)); end
    end
    bus.ena = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.clear = 1'b1; bus.ena = 1'b0;
    tick();
    bus.clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.ena = 1'b1; bus.select = 5'(i * 3); bus.in = 1'b1;
      tick();
    end
    total++; if (bus.count !== 6'd10) begin bad++; $display("FAIL mid_precount got=%0d exp=10", bus.count); end
    rst = 1'b1; bus.ena = 1'b1; bus.select = 5'd9; bus.in = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.out !== 32'h0 || bus.written !== 32'h0 || bus.count !== 6'd0 || bus.dup !== 1'b0 || bus.done !== 1'b0)
      begin bad++; $display("FAIL mid_reset got out=%h w=%h c=%0d dup=%b done=%b exp all 0",
                            bus.out, bus.written, bus.count, bus.dup, bus.done); end
    bus.ena = 1'b1; bus.select = 5'd3; bus.in = 1'b1;
    tick();
    bus.ena = 1'b0;
    total++; if (bus.count !== 6'd1) begin bad++; $display("FAIL mid_count got=%0d exp=1", bus.count); end
    total++; if (bus.out !== 32'h00000008) begin bad++; $display("FAIL mid_out got=%h exp=%h", bus.out, 32'h8); end
    total++; if (bus.written !== 32'h00000008) begin bad++; $display("FAIL mid_written got=%h exp=%h", bus.written, 32'h8); end
    total++; if (bus.dup !== 1'b0) begin bad++; $display("FAIL mid_dup got=%b exp=0", bus.dup); end
  endtask

  initial begin
    rst = 1'b1; bus.ena = 1'b0; bus.clear = 1'b0; bus.select = '0; bus.in = 1'b0;
    test_reset();
    test_fill();
    test_overwrite_full();
    test_clear();
    test_idle_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux32_collector.md
# demux32_collector

Sequential 1:N demultiplexer that collects single bits into an N-bit register word, one addressed bit per enabled cycle. It is the receive end of the bit-select path: where the 32:1 mux reads bit `d[select]` out of a word, this block writes bit `in` into position `select` of a stored word. It also tracks which positions have been filled since the last clear and flags when the word is complete. It sits downstream of any bit-serial source that supplies an index with each bit.

## Interface
- `N`, default 32: word width. Must be a power of two and at least 2.
- `S`, default `$clog2(N)`: select width. Derived; never overridden.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ena` input 1: write strobe. The bit is captured on a rising edge where `ena`=1.
- `clear` input 1: synchronous soft clear of word, mask and count.
- `select` input S: target bit position, 0..N-1.
- `in` input 1: data bit to store.
- `out` output N: stored word. Registered.
- `written` output N: mask of positions written since the last clear or reset. Registered.
- `count` output S+1: number of distinct positions written, 0..N. Registered.
- `done` output 1: high when `count`==N. Pure decode of the `count` register.
- `dup` output 1: one-cycle pulse after a write to an already-written position. Registered.

## Operation
- **Reset** (`rst`=1 at an edge): `out`=0, `written`=0, `count`=0, `dup`=0, hence `done`=0.
  - `rst` overrides `clear` and `ena`.
  - Reset mid-fill discards all collected bits.
- **Write** (`ena`=1, `clear`=0, `rst`=0):
  - `out[select]` <= `in`. All other bits of `out` hold.
  - If `written[select]`=0: set it, `count` <= `count`+1, `dup` <= 0.
  - If `written[select]`=1: mask and `count` hold, `dup` <= 1. The data bit is still overwritten.
- **Idle** (`ena`=0, `clear`=0): `out`, `written` and `count` hold; `dup` <= 0. Changes on `select` and `in` are ignored.
- **Clear** (`clear`=1, `ena`=0): `out`=0, `written`=0, `count`=0, `dup`=0.
- **Clear and write in the same cycle** (`clear`=1, `ena`=1): the clear applies first, then the write.
  - `out` = `in` placed at bit `select`, all other bits 0.
  - `written` = one-hot at `select`.
  - `count`=1, `dup`=0.
- **Full** (`count`==N): `done`=1.
  - Further writes still update `out`.
  - `count` saturates naturally, because every position is already written. Every such write pulses `dup`.
  - `count` can never exceed N.
- **Invariants**, always true:
  - `count` == popcount(`written`).
  - `done` == &`written`.
- **Width rules:**
  - `select` is always in range because N = 2^S; no out-of-range handling exists.
  - `count` is S+1 bits so that it can hold the value N.

## Timing
- Single clock domain, no combinational path from inputs to outputs.
- Write latency is 1 cycle: `out`, `written`, `count` and `dup` reflect a write immediately after the capturing edge.
- `done` rises in the same cycle that `count` becomes N, i.e. 1 cycle after the edge carrying the Nth distinct write.
- `dup` is high for exactly 1 cycle per duplicate write. Back-to-back duplicate writes hold it high continuously.
- Throughput: one bit per cycle, no stall and no backpressure. `ena` may be held high indefinitely.
- No state machine beyond the mask and counter; the block is ready every cycle, including the cycle after reset.

## Test plan
- **Reset:**
  - Stimulus: `rst`=1 for 2 cycles while `ena`=1, `select`=7, `in`=1.
  - Response: `out`=0, `written`=0, `count`=0, `done`=0, `dup`=0.
- **Sequential fill:**
  - Stimulus: write `select`=0..31 with `in` = bit i of 0xDEADBEEF.
  - Response: after the last edge `out`=0xDEADBEEF, `written`=0xFFFFFFFF, `count`=32, `done`=1. `dup` never asserts, and `done` is 0 after write 31 of 32.
- **Overwrite when full:**
  - Stimulus: after the fill, write `select`=5, `in`=0.
  - Response: `out`=0xDEADBECF, `count` stays 32, `done` stays 1, `dup`=1 for exactly one cycle.
- **Clear and clear-with-write:**
  - Stimulus: `clear` alone, then `clear`+`ena` with `select`=31, `in`=1.
  - Response: after the first edge all zeros. After the second `out`=0x80000000, `written`=0x80000000, `count`=1, `dup`=0.
- **Idle hold and random order:**
  - Stimulus: with `ena`=0, toggle `select` and `in` for 10 cycles; then 64 random writes.
  - Response: no output change while idle. During the random writes, every cycle matches the reference model: `count`==popcount(`written`), `dup` matches prior mask state, and `out[i]` equals the last bit written at i.
- **Reset mid-operation:**
  - Stimulus: after 10 distinct writes, assert `rst` for 1 cycle with `ena`=1.
  - Response: all outputs 0 the next cycle. A subsequent write to `select`=3 with `in`=1 gives `count`=1 and `out`=0x00000008.
